tw_regfile: RTL and testbench

Parametrised dual-access register file, successor to the current two-wire/register-port block. A parallel configuration port (cfg_*) and a two-wire serial slave port (SCL/SDA) share one array of 2^ADDR_W words of DATA_W bits. Unlike its predecessor, everything runs on the single system clock: SCL and SDA are oversampled rather than used as a clock. Serial writes commit as whole words, same-cycle write collisions are resolved by a parameter, and stalled serial frames are aborted by a timeout.

---
 rtl/tw_regfile_pkg.sv | 27 ++
 rtl/tw_sync.sv | 24 ++
 rtl/tw_regfile.sv | 216 +++++++++++++++++++++
 tb/tb_tw_regfile.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tw_regfile_pkg.sv
// Shared types and framing constants for the tw_regfile block.
// Both access ports and later two-wire blocks import this.
package tw_regfile_pkg;

    typedef enum logic [2:0] {
        TW_IDLE,
        TW_CMD,
        TW_ADDR,
        TW_WDATA,
        TW_COMMIT,
        TW_TURN,
        TW_RESP
    } tw_state_e;

    typedef enum logic [1:0] {
        CF_IDLE,
        CF_ACCESS,
        CF_DONE
    } cfg_state_e;

    localparam logic       CMD_WRITE = 1'b1;
    localparam logic       CMD_READ  = 1'b0;
    localparam int         TURN_BITS = 2;
    localparam logic [1:0] RESP_PRE  = 2'b01;
    localparam logic       RESP_POST = 1'b1;

endpackage

// File: rtl/tw_sync.sv
// Two-flop synchroniser with a rising-edge detector on the
// synchronised copy.
module tw_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign q_o    = sync_q[1];
    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tw_regfile.sv
// Register file shared by a parallel cfg port and an
// oversampled two-wire serial slave port.
module tw_regfile
    import tw_regfile_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int PRIO_TW = 0,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl,
    input  logic              sda_i,
    output logic              sda_o,
    output logic              sda_oe,
    input  logic              cfg_req,
    input  logic              cfg_cmd,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic              cfg_rdy,
    output logic [DATA_W-1:0] cfg_rdata,
    output logic              tw_busy,
    output logic              tw_abort
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int BW    = $clog2(DATA_W + ADDR_W + 4);
    localparam int TW    = $clog2(TIMEOUT + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    tw_state_e         tw_q;
    logic [BW-1:0]     bit_q;
    logic [TW-1:0]     tmo_q;
    logic              cmd_q;
    logic [ADDR_W-1:0] taddr_q;
    logic [DATA_W-1:0] sh_q;

    cfg_state_e        cf_q;
    logic              ccmd_q;
    logic [ADDR_W-1:0] caddr_q;
    logic [DATA_W-1:0] cwdata_q;

    logic ev;
    logic sda_s;
    logic scl_lvl_unused;
    logic sda_rise_unused;
    logic tmo_hit;
    logic tw_we;
    logic cfg_we;

    tw_sync u_scl (
        .clk    (clk),
        .reset  (reset),
        .d_i    (scl),
        .q_o    (scl_lvl_unused),
        .rise_o (ev)
    );

    tw_sync u_sda (
        .clk    (clk),
        .reset  (reset),
        .d_i    (sda_i),
        .q_o    (sda_s),
        .rise_o (sda_rise_unused)
    );

    assign tw_busy = (tw_q != TW_IDLE);
    assign tmo_hit = tw_busy && !ev && (tmo_q == TW'(TIMEOUT - 1));
    assign tw_we   = (tw_q == TW_COMMIT) && !tmo_hit && !reset;
    assign cfg_we  = (cf_q == CF_ACCESS) && (ccmd_q == CMD_WRITE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            tw_q     <= TW_IDLE;
            bit_q    <= '0;
            tmo_q    <= '0;
            cmd_q    <= CMD_READ;
            taddr_q  <= '0;
            sh_q     <= '0;
            sda_o    <= 1'b0;
            sda_oe   <= 1'b0;
            tw_abort <= 1'b0;
        end else begin
            tw_abort <= 1'b0;
            if (!tw_busy || ev) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (tmo_hit) begin
                tw_q     <= TW_IDLE;
                bit_q    <= '0;
                tmo_q    <= '0;
                sda_o    <= 1'b0;
                sda_oe   <= 1'b0;
                tw_abort <= 1'b1;
            end else begin
                unique case (tw_q)
                    TW_IDLE: begin
                        if (ev && !sda_s) tw_q <= TW_CMD;
                    end
                    TW_CMD: begin
                        if (ev) begin
                            cmd_q <= sda_s;
                            tw_q  <= TW_ADDR;
                        end
                    end
                    TW_ADDR: begin
                        if (ev) begin
                            taddr_q <= {sda_s, taddr_q[ADDR_W-1:1]};
                            if (bit_q == BW'(ADDR_W - 1)) begin
                                bit_q <= '0;
                                tw_q  <= (cmd_q == CMD_WRITE) ?
                                         TW_WDATA : TW_TURN;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                    TW_WDATA: begin
                        if (ev) begin
                            sh_q <= {sda_s, sh_q[DATA_W-1:1]};
                            if (bit_q == BW'(DATA_W - 1)) begin
                                bit_q <= '0;
                                tw_q  <= TW_COMMIT;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                    TW_COMMIT: begin
                        tw_q <= TW_IDLE;
                    end
                    TW_TURN: begin
                        if (ev) begin
                            if (bit_q == '0) sh_q <= mem_q[taddr_q];
                            if (bit_q == BW'(TURN_BITS - 1)) begin
                                bit_q  <= '0;
                                sda_oe <= 1'b1;
                                sda_o  <= RESP_PRE[0];
                                tw_q   <= TW_RESP;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                    TW_RESP: begin
                        // sh_q shifts out one data bit per event
                        if (ev) begin
                            bit_q <= bit_q + 1'b1;
                            if (bit_q == '0) begin
                                sda_o <= RESP_PRE[1];
                            end else if (bit_q <= BW'(DATA_W)) begin
                                sda_o <= sh_q[0];
                                sh_q  <= sh_q >> 1;
                            end else if (bit_q == BW'(DATA_W + 1)) begin
                                sda_o <= RESP_POST;
                            end else begin
                                sda_o  <= 1'b0;
                                sda_oe <= 1'b0;
                                bit_q  <= '0;
                                tw_q   <= TW_IDLE;
                            end
                        end
                    end
                    default: tw_q <= TW_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cf_q      <= CF_IDLE;
            ccmd_q    <= CMD_READ;
            caddr_q   <= '0;
            cwdata_q  <= '0;
            cfg_rdy   <= 1'b0;
            cfg_rdata <= '0;
        end else begin
            cfg_rdy <= 1'b0;
            unique case (cf_q)
                CF_IDLE: begin
                    if (cfg_req) begin
                        ccmd_q   <= cfg_cmd;
                        caddr_q  <= cfg_addr;
                        cwdata_q <= cfg_wdata;
                        cf_q     <= CF_ACCESS;
                    end
                end
                CF_ACCESS: begin
                    if (ccmd_q == CMD_READ) cfg_rdata <= mem_q[caddr_q];
                    cfg_rdy <= 1'b1;
                    cf_q    <= CF_DONE;
                end
                CF_DONE: cf_q <= CF_IDLE;
                default: cf_q <= CF_IDLE;
            endcase
        end
    end

    // Per-word collision mux: the loser only drops on a same-address hit
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (tw_we && taddr_q == ADDR_W'(i) &&
                (PRIO_TW != 0 || !(cfg_we && caddr_q == taddr_q))) begin
                mem_q[i] <= sh_q;
            end else if (cfg_we && caddr_q == ADDR_W'(i)) begin
                mem_q[i] <= cwdata_q;
            end
        end
    end

endmodule

// File: tb/tb_tw_regfile.sv
// Directed bench for tw_regfile: two instances differing only in
// collision priority, expectations held in scoreboard queues.
module tb_tw_regfile;

    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int TMO = 1024;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          scl   = 1'b0;
    logic          sda   = 1'b1;
    logic          req   = 1'b0;
    logic          cmd   = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;

    logic          o0, oe0, rdy0, busy0, ab0;
    logic          o1, oe1, rdy1, busy1, ab1;
    logic [DW-1:0] rd0, rd1;

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] cq0 [$];
    logic [DW-1:0] cq1 [$];
    logic [1:0]    sq  [$];

    always #5 clk = ~clk;

    tw_regfile #(.DATA_W(DW), .ADDR_W(AW), .PRIO_TW(0), .TIMEOUT(TMO)) u0 (
        .clk(clk), .reset(reset), .scl(scl), .sda_i(sda),
        .sda_o(o0), .sda_oe(oe0), .cfg_req(req), .cfg_cmd(cmd),
        .cfg_addr(addr), .cfg_wdata(wdata), .cfg_rdy(rdy0),
        .cfg_rdata(rd0), .tw_busy(busy0), .tw_abort(ab0)
    );

    tw_regfile #(.DATA_W(DW), .ADDR_W(AW), .PRIO_TW(1), .TIMEOUT(TMO)) u1 (
        .clk(clk), .reset(reset), .scl(scl), .sda_i(sda),
        .sda_o(o1), .sda_oe(oe1), .cfg_req(req), .cfg_cmd(cmd),
        .cfg_addr(addr), .cfg_wdata(wdata), .cfg_rdy(rdy1),
        .cfg_rdata(rd1), .tw_busy(busy1), .tw_abort(ab1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tw_bit(input logic b);
        sda = b;
        repeat (4) step();
        scl = 1'b1;
        repeat (4) step();
        scl = 1'b0;
    endtask

    task automatic tw_sample(output logic [1:0] v);
        sda = 1'b1;
        repeat (4) step();
        scl = 1'b1;
        step();
        step();
        v = {oe0, o0};
        step();
        step();
        scl = 1'b0;
    endtask

    task automatic tw_hdr(input logic c, input logic [AW-1:0] a);
        tw_bit(1'b0);
        tw_bit(c);
        for (int i = 0; i < AW; i++) tw_bit(a[i]);
    endtask

    task automatic tw_data(input logic [DW-1:0] d, input int lo,
                           input int hi);
        for (int i = lo; i < hi; i++) tw_bit(d[i]);
    endtask

    task automatic tw_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tw_hdr(1'b1, a);
        tw_data(d, 0, DW);
    endtask

    task automatic tw_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [1:0] v;
        logic [1:0] e;
        sq.push_back(2'b00);
        sq.push_back(2'b00);
        sq.push_back(2'b11);
        sq.push_back(2'b10);
        for (int i = 0; i < DW; i++) sq.push_back({1'b1, d[i]});
        sq.push_back(2'b11);
        tw_hdr(1'b0, a);
        chk("tw_busy_rd", busy0, 1);
        while (sq.size() > 0) begin
            tw_sample(v);
            e = sq.pop_front();
            chk("tw_rd_bit", v, e);
        end
        chk("tw_busy_end", busy0, 0);
        chk("tw_oe_end", oe0, 0);
    endtask

    task automatic cfg_op(input logic c, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] e0,
                          input logic [DW-1:0] e1);
        int lat;
        logic [DW-1:0] x0;
        logic [DW-1:0] x1;
        req   = 1'b1;
        cmd   = c;
        addr  = a;
        wdata = d;
        if (!c) begin
            cq0.push_back(e0);
            cq1.push_back(e1);
        end
        step();
        req = 1'b0;
        lat = 1;
        while (!rdy0 && lat < 8) begin
            step();
            lat++;
        end
        chk("cfg_lat", lat, 2);
        chk("cfg_rdy1", rdy1, 1);
        if (!c) begin
            x0 = cq0.pop_front();
            x1 = cq1.pop_front();
            chk("cfg_rdata0", rd0, x0);
            chk("cfg_rdata1", rd1, x1);
        end
        step();
        chk("cfg_rdy_pulse", rdy0, 0);
    endtask

    task automatic tw_collide(input logic [AW-1:0] ta, input logic [DW-1:0] td,
                              input logic [AW-1:0] ca, input logic [DW-1:0] cd);
        tw_hdr(1'b1, ta);
        tw_data(td, 0, DW - 1);
        sda = td[DW-1];
        repeat (4) step();
        scl = 1'b1;
        step();
        step();
        req   = 1'b1;
        cmd   = 1'b1;
        addr  = ca;
        wdata = cd;
        step();
        req = 1'b0;
        step();
        scl = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ab;
        int at;
        int n_rdy;
        logic [1:0] v;

        repeat (3) step();
        chk("rst_rdy", rdy0, 0);
        chk("rst_rdata", rd0, 0);
        chk("rst_sda_o", o0, 0);
        chk("rst_sda_oe", oe0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_abort", ab0, 0);
        reset = 1'b0;
        step();

        cfg_op(1'b1, 8'h12, 16'hBEEF, '0, '0);
        cfg_op(1'b0, 8'h12, '0, 16'hBEEF, 16'hBEEF);

        cfg_op(1'b1, 8'h34, 16'h0000, '0, '0);
        tw_hdr(1'b1, 8'h34);
        tw_data(16'hA5C3, 0, DW - 1);
        chk("tw_busy_wr", busy0, 1);
        cfg_op(1'b0, 8'h34, '0, 16'h0000, 16'h0000);
        tw_data(16'hA5C3, DW - 1, DW);
        cfg_op(1'b0, 8'h34, '0, 16'hA5C3, 16'hA5C3);
        chk("tw_busy_wr_end", busy0, 0);

        cfg_op(1'b1, 8'h56, 16'h1234, '0, '0);
        tw_read(8'h56, 16'h1234);

        tw_collide(8'h78, 16'h1111, 8'h78, 16'h2222);
        cfg_op(1'b0, 8'h78, '0, 16'h2222, 16'h1111);
        tw_collide(8'h78, 16'h3333, 8'h79, 16'h4444);
        cfg_op(1'b0, 8'h78, '0, 16'h3333, 16'h3333);
        cfg_op(1'b0, 8'h79, '0, 16'h4444, 16'h4444);

        cfg_op(1'b1, 8'h9A, 16'h5555, '0, '0);
        tw_hdr(1'b1, 8'h9A);
        tw_data(16'hFFFF, 0, 5);
        n_ab = 0;
        at   = -1;
        for (int i = 0; i < TMO + 200; i++) begin
            step();
            if (ab0) begin
                n_ab++;
                at = i;
            end
        end
        chk("abort_count", n_ab, 1);
        chk("abort_time", (at >= TMO - 4 && at <= TMO + 2), 1);
        chk("abort_busy", busy0, 0);
        chk("abort_oe", oe0, 0);
        cfg_op(1'b0, 8'h9A, '0, 16'h5555, 16'h5555);
        sda = 1'b1;
        tw_write(8'h9A, 16'h0F0F);
        cfg_op(1'b0, 8'h9A, '0, 16'h0F0F, 16'h0F0F);

        tw_hdr(1'b0, 8'h56);
        for (int i = 0; i < 5; i++) tw_sample(v);
        chk("mid_rd_oe", oe0, 1);
        req   = 1'b1;
        cmd   = 1'b1;
        addr  = 8'h56;
        wdata = 16'hDEAD;
        step();
        reset = 1'b1;
        req   = 1'b0;
        n_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rdy0) n_rdy++;
        end
        chk("mrst_oe", oe0, 0);
        chk("mrst_busy", busy0, 0);
        chk("mrst_rdy", n_rdy, 0);
        chk("mrst_rdata", rd0, 0);
        sda   = 1'b1;
        reset = 1'b0;
        step();
        cfg_op(1'b0, 8'h56, '0, 16'h1234, 16'h1234);
        tw_read(8'h56, 16'h1234);
        cfg_op(1'b1, 8'h56, 16'hCAFE, '0, '0);
        cfg_op(1'b0, 8'h56, '0, 16'hCAFE, 16'hCAFE);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
